// File: rtl/p2s_rr_sched_if.sv
// Requester/serial-link bundle for p2s_rr_sched: per-requester words and
// requests in, one-hot grant and qualified serial stream out.
interface p2s_rr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*WIDTH-1:0] data_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic                     serial_o;
  logic                     valid_o;
  logic [SRC_W-1:0]         src_o;
  logic                     empty_o;

  // Requester side: drives words and requests, watches grant and stream.
  modport master (
    output req_i, data_i,
    input  gnt_o, serial_o, valid_o, src_o, empty_o
  );

  // Scheduler side.
  modport slave (
    input  req_i, data_i,
    output gnt_o, serial_o, valid_o, src_o, empty_o
  );
endinterface

// File: rtl/p2s_rr_sched.sv
// Round-robin scheduler sharing one LSB-first parallel-to-serial path between
// NUM_REQ requesters, with back-to-back words and no idle gap.
module p2s_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  p2s_rr_sched_if.slave  bus
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [SRC_W-1:0] LAST_REQ = SRC_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  generate
    if (NUM_REQ < 2) begin : g_bad_num_req
      $error("p2s_rr_sched: NUM_REQ must be at least 2");
    end
    if (WIDTH < 2) begin : g_bad_width
      $error("p2s_rr_sched: WIDTH must be at least 2");
    end
  endgenerate

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   sr;
  logic [CNT_W-1:0]   cnt;
  logic [SRC_W-1:0]   ptr;
  logic [SRC_W-1:0]   src;

  logic               last_bit;
  logic               ready;
  logic               grant;
  logic [SRC_W-1:0]   win_idx;
  logic [WIDTH-1:0]   win_word;
  logic [NUM_REQ-1:0] gnt;
  logic [SRC_W-1:0]   ptr_next;

  // Per-requester word view of the packed data bus.
  logic [WIDTH-1:0] words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = bus.data_i[g*WIDTH +: WIDTH];
  end

  assign last_bit = (state == S_SHIFT) && (cnt == LAST_BIT);
  assign ready    = (state == S_IDLE) || last_bit;

  // Rotating priority: first request at or above ptr, otherwise the lowest
  // request below it. Reset low blanks the grant so nothing is captured.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    grant    = 1'b0;
    win_idx  = '0;
    win_word = '0;
    gnt      = '0;
    if (ready && reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant && (k >= int'(ptr)) && bus.req_i[k]) begin
          grant    = 1'b1;
          win_idx  = SRC_W'(k);
          win_word = words[k];
          gnt[k]   = 1'b1;
        end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant && bus.req_i[k]) begin
          grant    = 1'b1;
          win_idx  = SRC_W'(k);
          win_word = words[k];
          gnt[k]   = 1'b1;
        end
      end
    end
  end

  assign ptr_next = (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;

  // A grant always wins over the shift step, which is what lets the next
  // word start in the cycle right after the previous word's last bit.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments only, so every
    // register in this block sees the pre-edge values of the others.
    if (!reset) begin
      state <= S_IDLE;
      sr    <= '0;
      cnt   <= '0;
      ptr   <= '0;
      src   <= '0;
    end else if (grant) begin
      state <= S_SHIFT;
      sr    <= win_word;
      cnt   <= '0;
      ptr   <= ptr_next;
      src   <= win_idx;
    end else if (state == S_SHIFT) begin
      sr <= sr >> 1;
      if (last_bit) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // sr shifts in zeros, so it is all-zero whenever the path is idle and
  // serial_o idles low without extra gating.
  assign bus.gnt_o    = gnt;
  assign bus.serial_o = sr[0];
  assign bus.valid_o  = (state == S_SHIFT);
  assign bus.empty_o  = (state != S_SHIFT);
  assign bus.src_o    = src;

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!reset)
    $onehot0(gnt));

  a_gnt_when_ready : assert property (@(posedge clk) disable iff (!reset)
    (|gnt) |-> ready);

  a_empty_matches_valid : assert property (@(posedge clk) disable iff (!reset)
    bus.empty_o == !bus.valid_o);

  a_ptr_in_range : assert property (@(posedge clk) disable iff (!reset)
    ptr <= LAST_REQ);

endmodule

// File: doc/p2s_rr_sched.md
# p2s_rr_sched

Round-robin scheduler that shares one parallel-to-serial shift path between `NUM_REQ` requesters. Each requester presents a `WIDTH`-bit word with a request line. The block arbitrates between them, loads the winning word, and shifts it out LSB-first on a single serial line with a valid qualifier. Back-to-back words are serialized with no idle cycle. It sits in front of the shared serial link, in place of a single-source serializer.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, minimum 2.
- `WIDTH`, 4: bits per word, minimum 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `req_i`  in  NUM_REQ  per-requester request; level, held until granted.
- `data_i`  in  NUM_REQ*WIDTH  word for requester k at bits [k*WIDTH +: WIDTH]; stable while `req_i[k]`=1.
- `gnt_o`  out  NUM_REQ  one-hot grant, combinational, one-cycle pulse; word captured at the edge ending that cycle.
- `serial_o`  out  1  serialized bit, registered.
- `valid_o`  out  1  `serial_o` carries a valid bit, registered.
- `src_o`  out  max(1,$clog2(NUM_REQ))  index of the requester whose word is on `serial_o`, registered.
- `empty_o`  out  1  high when no word is in flight (equals ~`valid_o`).

## Operation
- State: `IDLE`, `SHIFT`.
- Registers: shift register `sr[WIDTH-1:0]`, bit counter `cnt` (0..WIDTH-1), round-robin pointer `ptr` (0..NUM_REQ-1), `src_o`.
- `ready` = (state==IDLE) or (state==SHIFT and cnt==WIDTH-1).
- Arbitration, evaluated only when `ready`=1: search `req_i` starting at index `ptr`, wrapping modulo NUM_REQ. The first set index k wins and `gnt_o[k]`=1. When `ready`=0, `gnt_o`=0.
- On a grant edge:
  - load `sr` ← word k and `src_o` ← k;
  - set `cnt` ← 0 and state ← SHIFT;
  - set `ptr` ← (k+1) mod NUM_REQ.
- In SHIFT:
  - `serial_o` = `sr[0]` and `valid_o`=1;
  - each edge shifts `sr` right and increments `cnt`;
  - on the edge with cnt==WIDTH-1 and no grant, go to IDLE.
- `ptr` changes only on a grant. A requester that is skipped keeps its place.
- A requester that sees `gnt_o[k]`=1 may drop `req_i[k]` or present its next word from the following cycle. A request withdrawn before its grant is never granted.
- `req_i` changes outside `ready` cycles have no effect until the next `ready` cycle.

## Timing
- Reset values: state=IDLE, `sr`=0, `cnt`=0, `ptr`=0, `src_o`=0, `serial_o`=0, `valid_o`=0, `empty_o`=1, `gnt_o`=0.
- Latency: grant in cycle C → bit 0 on `serial_o` in C+1, bit WIDTH-1 in C+WIDTH. `valid_o` is high C+1..C+WIDTH.
- Back-to-back: a grant in the last-bit cycle makes the next word's bit 0 appear in the following cycle. `valid_o` stays high with no gap, and `src_o` switches on that same edge.
- Sustained throughput: one word per WIDTH cycles.
- Idle with no requests: `valid_o`=0, `serial_o`=0, `empty_o`=1.
- Reset asserted mid-word clears all state at once, without waiting for a clock edge. The partial word is dropped, not resumed. After release, arbitration restarts from index 0.
- Reset asserted in a cycle where `gnt_o`=1 suppresses the capture. `gnt_o` is forced to 0 while reset is low.

## Test plan
Configuration for all tests: NUM_REQ=4, WIDTH=4.
1. Reset, then `req_i`=0 for 10 cycles → `valid_o`=0, `serial_o`=0, `empty_o`=1 and `gnt_o`=0 throughout.
2. `req_i`=4'b0001, word0=4'hA, dropped after the grant → `gnt_o`=0001 for 1 cycle. Then `serial_o`=0,1,0,1 over the next 4 cycles with `valid_o`=1 and `src_o`=0, then `empty_o`=1.
3. `req_i`=4'b1111 held, words 1,2,3,4 → grants go 0,1,2,3,0 every 4 cycles. `valid_o` is continuously high from the first bit. `src_o` steps 0,1,2,3 and each word is serialized LSB-first.
4. `req_i`=4'b0101 held, words 4'h3, 4'hC → grants alternate 0,2,0,2. Serial stream is 1,1,0,0,0,0,1,1,… with no gaps.
5. Requester 1 active; assert reset after 2 bits of 4'hF → outputs go to reset values immediately. After release with `req_i`=4'b0010, the grant goes to 1 and all 4 bits of the word are sent.
6. `req_i[3]` pulsed high for 1 cycle during SHIFT (not a ready cycle), then low → no grant to 3 ever. `ptr` and the ongoing word are unaffected.
